// File: rtl/control_unit_if.sv
// Control-unit bus: fetched opcode and ALU flags in, datapath control word out.
// master = control unit, slave = datapath.
interface control_unit_if;
    logic [4:0] Oi;
    logic       IFgn;
    logic       IFgz;
    logic       LRCR;
    logic [1:0] mux1CR;
    logic       PCCR;
    logic       RegCR;
    logic       mux2CR;
    logic [3:0] OPALU;
    logic       NFCR;
    logic       ZFCR;
    logic       DMCR;
    logic [1:0] WBCR;
    logic       Reg1CR;
    logic       Reg2CR;

    modport master (
        input  Oi, IFgn, IFgz,
        output LRCR, mux1CR, PCCR, RegCR, mux2CR, OPALU,
               NFCR, ZFCR, DMCR, WBCR, Reg1CR, Reg2CR
    );

    modport slave (
        output Oi, IFgn, IFgz,
        input  LRCR, mux1CR, PCCR, RegCR, mux2CR, OPALU,
               NFCR, ZFCR, DMCR, WBCR, Reg1CR, Reg2CR
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Every strobe is registered and lasts one cycle. `state` names the phase whose
// control word is loaded onto the outputs at the next rising edge, so the first
// LRCR appears in the first clock after reset release.
// Optional build macro CU_STEP_EN adds a single-step input that gates FETCH.
module control_unit #(
    parameter bit         HALT_EN  = 1'b1,
    parameter logic [3:0] ALU_PASS = 4'hA
) (
    input  logic clk,
    input  logic rst,
`ifdef CU_STEP_EN
    input  logic step,
`endif
    control_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t     state;
    logic [4:0] op_q;
    logic [3:0] op_in;
    logic [3:0] op;

    assign op_in = bus.Oi[4:1];
    assign op    = op_q[4:1];

    // Sequencer state, latched opcode and the registered control word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_FETCH;
            op_q       <= 5'd0;
            bus.LRCR   <= 1'b0;
            bus.mux1CR <= 2'b10;
            bus.PCCR   <= 1'b0;
            bus.RegCR  <= 1'b0;
            bus.mux2CR <= 1'b0;
            bus.OPALU  <= ALU_PASS;
            bus.NFCR   <= 1'b0;
            bus.ZFCR   <= 1'b0;
            bus.DMCR   <= 1'b0;
            bus.WBCR   <= 2'b00;
            bus.Reg1CR <= 1'b0;
            bus.Reg2CR <= 1'b0;
        end else begin
            bus.LRCR   <= 1'b0;
            bus.mux1CR <= 2'b10;
            bus.PCCR   <= 1'b0;
            bus.RegCR  <= 1'b0;
            bus.mux2CR <= 1'b0;
            bus.OPALU  <= ALU_PASS;
            bus.NFCR   <= 1'b0;
            bus.ZFCR   <= 1'b0;
            bus.DMCR   <= 1'b0;
            bus.WBCR   <= 2'b00;
            bus.Reg1CR <= 1'b0;
            bus.Reg2CR <= 1'b0;
            case (state)
                S_FETCH: begin
`ifdef CU_STEP_EN
                    if (step) begin
                        bus.LRCR <= 1'b1;
                        state    <= S_DECODE;
                    end
`else
                    bus.LRCR <= 1'b1;
                    state    <= S_DECODE;
`endif
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    // The instruction register has settled by the end of the
                    // DECODE cycle; capture it here and never look at Oi again.
                    op_q <= bus.Oi;
                    if (HALT_EN && op_in == 4'hF) begin
                        state <= S_HALT;
                    end else begin
                        if (op_in >= 4'h1 && op_in <= 4'h6) begin
                            bus.OPALU <= op_in;
                            bus.NFCR  <= 1'b1;
                            bus.ZFCR  <= 1'b1;
                        end
                        state <= (op_in == 4'h8 || op_in == 4'h9) ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    if (op == 4'h9) bus.DMCR <= 1'b1;
                    state <= S_WB;
                end
                S_WB: begin
                    bus.PCCR   <= 1'b1;
                    bus.mux1CR <= 2'b00;
                    case (op)
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: bus.RegCR <= 1'b1;
                        4'h7: begin bus.RegCR <= 1'b1; bus.WBCR <= 2'b11; end
                        4'h8: begin bus.RegCR <= 1'b1; bus.WBCR <= 2'b01; end
                        4'hA: begin bus.RegCR <= 1'b1; bus.WBCR <= 2'b10; end
                        4'hB: begin bus.RegCR <= 1'b1; bus.mux2CR <= 1'b1; end
                        4'hC: begin
                            if (op_q[0]) bus.Reg2CR <= 1'b1;
                            else         bus.Reg1CR <= 1'b1;
                        end
                        4'hD: bus.mux1CR <= 2'b01;
                        // JZ on sub-bit 0, JN on sub-bit 1; flags sampled now.
                        4'hE: if (op_q[0] ? bus.IFgn : bus.IFgz) bus.mux1CR <= 2'b01;
                        default: ;
                    endcase
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes the expected per-cycle
// control word, a negedge monitor pops and compares against the DUT outputs.
module tb_control_unit;

    typedef struct packed {
        logic       lr;
        logic [1:0] m1;
        logic       pc;
        logic       rg;
        logic       m2;
        logic [3:0] op;
        logic       nf;
        logic       zf;
        logic       dm;
        logic [1:0] wb;
        logic       r1;
        logic       r2;
    } cw_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef CU_STEP_EN
    logic step = 1'b1;
`endif

    always #5 clk = ~clk;

    control_unit_if bus();

    control_unit dut (
        .clk (clk),
        .rst (rst),
`ifdef CU_STEP_EN
        .step(step),
`endif
        .bus (bus)
    );

    cw_t   exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    cw_t   mon_e;
    cw_t   mon_a;
    string mon_n;

    function automatic cw_t dflt();
        cw_t c;
        c    = '0;
        c.m1 = 2'b10;
        c.op = 4'hA;
        return c;
    endfunction

    // Base write-back word: PC advances to PC+1.
    function automatic cw_t wbase();
        cw_t c;
        c    = dflt();
        c.pc = 1'b1;
        c.m1 = 2'b00;
        return c;
    endfunction

    function automatic cw_t sample();
        cw_t c;
        c.lr = bus.LRCR;   c.m1 = bus.mux1CR; c.pc = bus.PCCR;
        c.rg = bus.RegCR;  c.m2 = bus.mux2CR; c.op = bus.OPALU;
        c.nf = bus.NFCR;   c.zf = bus.ZFCR;   c.dm = bus.DMCR;
        c.wb = bus.WBCR;   c.r1 = bus.Reg1CR; c.r2 = bus.Reg2CR;
        return c;
    endfunction

    // Monitor: compare one expected control word per cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            mon_a = sample();
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", mon_n, mon_a, mon_e);
            end
        end
    end

    task automatic push(input string n, input cw_t c);
        exp_q.push_back(c);
        name_q.push_back(n);
    endtask

    // Push a full instruction's expected words, then clock it through.
    // Oi switches to `late` right after the cycle in which it is captured.
    task automatic issue(input string n, input logic [4:0] oi, input logic [4:0] late,
                         input logic gz, input logic gn,
                         input cw_t ex, input cw_t mem, input cw_t wb, input bit has_mem);
        cw_t f;
        f    = dflt();
        f.lr = 1'b1;
        push({n, "_fetch"}, f);
        push({n, "_decode"}, dflt());
        push({n, "_exec"}, ex);
        if (has_mem) push({n, "_mem"}, mem);
        push({n, "_wb"}, wb);
        bus.Oi   = oi;
        bus.IFgz = gz;
        bus.IFgn = gn;
        repeat (3) @(posedge clk);
        #1 bus.Oi = late;
        repeat (has_mem ? 2 : 1) @(posedge clk);
        #1;
    endtask

    initial begin
        cw_t ex, mem, wb, f;
        bus.Oi   = 5'd0;
        bus.IFgz = 1'b0;
        bus.IFgn = 1'b0;
        rst      = 1'b0;

        repeat (2) @(posedge clk);
        #1 push("reset", dflt());
        @(negedge clk);
        #1 rst = 1'b1;

        // ALU ops
        ex = dflt(); ex.op = 4'h1; ex.nf = 1; ex.zf = 1;
        wb = wbase(); wb.rg = 1;
        issue("add", 5'b00010, 5'b00010, 0, 0, ex, dflt(), wb, 0);
        ex.op = 4'h2;
        issue("sub", 5'b00100, 5'b00100, 0, 0, ex, dflt(), wb, 0);
        ex.op = 4'h6;
        issue("not", 5'b01100, 5'b01100, 0, 0, ex, dflt(), wb, 0);

        // Register writes from other sources
        wb = wbase(); wb.rg = 1; wb.wb = 2'b11;
        issue("ldi", 5'b01110, 5'b01110, 0, 0, dflt(), dflt(), wb, 0);
        wb = wbase(); wb.rg = 1; wb.wb = 2'b01;
        issue("ld", 5'b10000, 5'b10000, 0, 0, dflt(), dflt(), wb, 1);
        mem = dflt(); mem.dm = 1;
        issue("st", 5'b10010, 5'b10010, 0, 0, dflt(), mem, wbase(), 1);
        wb = wbase(); wb.rg = 1; wb.wb = 2'b10;
        issue("mov", 5'b10100, 5'b10100, 0, 0, dflt(), dflt(), wb, 0);
        wb = wbase(); wb.rg = 1; wb.m2 = 1;
        issue("in", 5'b10110, 5'b10110, 0, 0, dflt(), dflt(), wb, 0);
        issue("nop", 5'b00000, 5'b00000, 0, 0, dflt(), dflt(), wbase(), 0);

        // Branches
        wb = wbase(); wb.m1 = 2'b01;
        issue("jmp", 5'b11010, 5'b11010, 0, 0, dflt(), dflt(), wb, 0);
        issue("jz_taken", 5'b11100, 5'b11100, 1, 0, dflt(), dflt(), wb, 0);
        issue("jz_not", 5'b11100, 5'b11100, 0, 1, dflt(), dflt(), wbase(), 0);
        issue("jn_taken", 5'b11101, 5'b11101, 0, 1, dflt(), dflt(), wb, 0);
        issue("jn_not", 5'b11101, 5'b11101, 1, 0, dflt(), dflt(), wbase(), 0);

        // Output port latches; a late Oi change must not alter the choice
        wb = wbase(); wb.r1 = 1;
        issue("out1", 5'b11000, 5'b11001, 0, 0, dflt(), dflt(), wb, 0);
        wb = wbase(); wb.r2 = 1;
        issue("out2", 5'b11001, 5'b11000, 0, 0, dflt(), dflt(), wb, 0);

        // Reset while ST sits just before MEM: DMCR and PCCR must never appear
        f = dflt(); f.lr = 1;
        push("st_rst_fetch", f);
        push("st_rst_decode", dflt());
        push("st_rst_exec", dflt());
        bus.Oi = 5'b10010;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) push("st_rst_hold", dflt());
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        ex = dflt(); ex.op = 4'h1; ex.nf = 1; ex.zf = 1;
        wb = wbase(); wb.rg = 1;
        issue("add_after_rst", 5'b00010, 5'b00010, 0, 0, ex, dflt(), wb, 0);

        // HALT absorbs: nothing for 20 cycles
        push("halt_fetch", f);
        push("halt_decode", dflt());
        repeat (20) push("halt_idle", dflt());
        bus.Oi = 5'b11110;
        repeat (22) @(posedge clk);
        #1;

        // Drain the scoreboard with a bounded wait
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
